audio_i2s_tx: RTL



---
 rtl/audio_i2s_tx.sv | 104 ++++++++++
 1 files changed

// File: rtl/audio_i2s_tx.sv
// Stereo I2S transmitter: a small pair FIFO feeds a standard I2S serializer.
// BCLK/LRCLK are derived from clk; an empty FIFO at frame start repeats the last pair.
module audio_i2s_tx #(
  parameter int IW       = 16,
  parameter int BCLK_DIV = 19,
  parameter int DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [IW-1:0]            snd_l_in,
  input  logic [IW-1:0]            snd_r_in,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     underrun,
  output logic                     i2s_bclk,
  output logic                     i2s_lrclk,
  output logic                     i2s_sdata
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(BCLK_DIV);
  localparam int SW = $clog2(2 * IW);

  localparam logic [TW-1:0] TICK_LAST  = TW'(BCLK_DIV - 1);
  localparam logic [SW-1:0] SLOT_LAST  = SW'(2 * IW - 1);
  localparam logic [SW-1:0] SLOT_RIGHT = SW'(IW);
  localparam logic [AW:0]   FULL_LEVEL = (AW + 1)'(DEPTH);

  logic [2*IW-1:0] mem [DEPTH];

  logic [TW-1:0]   tick_reg;
  logic [SW-1:0]   slot_reg;
  logic [AW:0]     wr_ptr_reg;
  logic [AW:0]     rd_ptr_reg;
  logic [2*IW-1:0] pair_reg;

  logic            tick_wrap;
  logic            fall;
  logic            frame_start;
  logic            empty;
  logic            push;
  logic [SW-1:0]   slot_next;
  logic [2*IW-1:0] slot_bits;

  assign tick_wrap   = (tick_reg == TICK_LAST);
  assign fall        = tick_wrap && i2s_bclk;
  assign slot_next   = (slot_reg == SLOT_LAST) ? '0 : slot_reg + 1'b1;
  assign frame_start = fall && (slot_next == '0);

  assign level    = wr_ptr_reg - rd_ptr_reg;
  assign empty    = (wr_ptr_reg == rd_ptr_reg);
  assign in_ready = (level != FULL_LEVEL);
  assign push     = in_valid && in_ready;

  // Bit carried in each slot, with pair_reg = {L, R}: slot s sends pair_reg[(2*IW - s) mod 2*IW].
  // Slot 0 therefore sends R[0] of the pair still held when that slot is entered.
  genvar gi;
  generate
    for (gi = 0; gi < 2 * IW; gi++) begin : g_slot_map
      assign slot_bits[gi] = pair_reg[(2 * IW - gi) % (2 * IW)];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset_n && push) begin
      mem[wr_ptr_reg[AW-1:0]] <= {snd_l_in, snd_r_in};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tick_reg   <= '0;
      slot_reg   <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      pair_reg   <= '0;
      i2s_bclk   <= 1'b0;
      i2s_lrclk  <= 1'b0;
      i2s_sdata  <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      tick_reg <= tick_wrap ? '0 : tick_reg + 1'b1;
      if (tick_wrap) begin
        i2s_bclk <= !i2s_bclk;
      end
      underrun <= frame_start && empty;
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (fall) begin
        slot_reg  <= slot_next;
        i2s_lrclk <= (slot_next >= SLOT_RIGHT);
        i2s_sdata <= slot_bits[slot_next];
        // Pop reads the old rd pointer, so a same-cycle push is never seen by this pop.
        if (frame_start && !empty) begin
          pair_reg   <= mem[rd_ptr_reg[AW-1:0]];
          rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
      end
    end
  end

endmodule
